// File: rtl/transport_pkg.sv
// Shared transport-layer definitions: header coding, packet geometry and FSM states.
// The receive side parses packets with the same header constants.
package transport_pkg;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;

  localparam int PACKET_BYTES_DEFAULT = 16;

  // Byte offsets inside a packet
  localparam int OFF_HDR     = 0;
  localparam int OFF_PHONE   = 1;
  localparam int OFF_CMD     = 2;
  localparam int OFF_DATA_HI = 3;
  localparam int OFF_DATA_LO = 4;
  localparam int OFF_AUDIO   = 2;

  typedef enum logic {IDLE, SEND} txState_t;

endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous sample FIFO between the session layer and the packet framer.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module tx_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  // Pointers wrap explicitly so DEPTH need not be a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      if (doPop)  rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/transport_send.sv
// Transmit side of the transport layer: frames control commands and buffered
// audio samples into fixed-size byte packets streamed to the link layer.
module transport_send
  import transport_pkg::*;
#(
  parameter int PACKET_BYTES    = PACKET_BYTES_DEFAULT,
  parameter int AUDIO_DEPTH     = 8,
  parameter int SAMPLES_PER_PKT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [7:0]  phone_num,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  input  logic        audio_valid,
  input  logic [15:0] audio_sample,
  output logic        audio_ready,
  input  logic        net_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  output logic        tx_last,
  output logic        busy
);

  localparam int IW = $clog2(PACKET_BYTES);
  localparam int CW = $clog2(AUDIO_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PACKET_BYTES - 1);
  localparam logic [IW-1:0] AUDIO_END = IW'(OFF_AUDIO + 2 * SAMPLES_PER_PKT - 1);

  txState_t      state;
  logic [IW-1:0] byteIdx;
  logic          isAudio;
  logic [7:0]    phoneReg;
  logic [1:0]    cmdReg;
  logic [15:0]   dataReg;
  logic          cmdReadyReg;
  logic          txValidReg;
  logic          txStartReg;
  logic          txLastReg;
  logic          busyReg;

  logic [15:0]   fifoDout;
  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          pushSample;
  logic          popWanted;
  logic          popSample;
  logic          inAudioPayload;

  assign audio_ready = !reset && !fifoFull;
  assign pushSample  = audio_valid && audio_ready;

  assign inAudioPayload = (byteIdx >= IW'(OFF_AUDIO)) && (byteIdx <= AUDIO_END);
  // The head sample is retired when its low byte (odd index) is accepted
  assign popWanted = (state == SEND) && net_ready && isAudio && inAudioPayload && byteIdx[0];
  assign popSample = popWanted && !fifoEmpty;

  tx_sample_fifo #(
    .WIDTH (16),
    .DEPTH (AUDIO_DEPTH)
  ) sampleFifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushSample),
    .din   (audio_sample),
    .pop   (popSample),
    .dout  (fifoDout),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Packet FSM: launch decision in IDLE, one byte per accepted cycle in SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byteIdx     <= '0;
      isAudio     <= 1'b0;
      phoneReg    <= '0;
      cmdReg      <= '0;
      dataReg     <= '0;
      cmdReadyReg <= 1'b0;
      txValidReg  <= 1'b0;
      txStartReg  <= 1'b0;
      txLastReg   <= 1'b0;
      busyReg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmdReadyReg <= 1'b1;
          if (cmdReadyReg && (cmd_valid || fifoCount >= CW'(SAMPLES_PER_PKT))) begin
            state       <= SEND;
            byteIdx     <= '0;
            isAudio     <= !cmd_valid;
            phoneReg    <= phone_num;
            cmdReg      <= cmd;
            dataReg     <= cmd_data;
            cmdReadyReg <= 1'b0;
            txValidReg  <= 1'b1;
            txStartReg  <= 1'b1;
            txLastReg   <= 1'b0;
            busyReg     <= 1'b1;
          end
        end
        SEND: begin
          if (net_ready) begin
            if (byteIdx == LAST_IDX) begin
              state       <= IDLE;
              byteIdx     <= '0;
              cmdReadyReg <= 1'b1;
              txValidReg  <= 1'b0;
              txStartReg  <= 1'b0;
              txLastReg   <= 1'b0;
              busyReg     <= 1'b0;
            end else begin
              byteIdx    <= byteIdx + 1'b1;
              txStartReg <= 1'b0;
              txLastReg  <= (byteIdx + 1'b1 == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte content is decoded from registered packet state, so it holds during stalls
  always_comb begin
    tx_byte = '0;
    if (txValidReg) begin
      if (byteIdx == IW'(OFF_HDR)) begin
        tx_byte = isAudio ? HDR_AUDIO : HDR_CTRL;
      end else if (byteIdx == IW'(OFF_PHONE)) begin
        tx_byte = phoneReg;
      end else if (isAudio) begin
        if (inAudioPayload) tx_byte = byteIdx[0] ? fifoDout[7:0] : fifoDout[15:8];
      end else if (byteIdx == IW'(OFF_CMD)) begin
        tx_byte = {6'b0, cmdReg};
      end else if (byteIdx == IW'(OFF_DATA_HI)) begin
        tx_byte = dataReg[15:8];
      end else if (byteIdx == IW'(OFF_DATA_LO)) begin
        tx_byte = dataReg[7:0];
      end
    end
  end

  assign cmd_ready = cmdReadyReg;
  assign tx_valid  = txValidReg;
  assign tx_start  = txStartReg;
  assign tx_last   = txLastReg;
  assign busy      = busyReg;

endmodule

// File: tb/tb_transport_send.sv
// Directed self-checking bench for transport_send: framing, back-pressure,
// launch priority, FIFO full behaviour and mid-packet reset.
module tb_transport_send;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [7:0]  phone_num;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        audio_valid;
  logic [15:0] audio_sample;
  logic        audio_ready;
  logic        net_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] capBytes [16];
  logic       capStart [16];
  logic       capLast  [16];
  logic [7:0] expBytes [16];
  int         capCount;
  int         capBusy;
  int         capHoldErr;
  int         capStalls;
  logic [7:0] capStallByte;

  transport_send dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .phone_num    (phone_num),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .audio_valid  (audio_valid),
    .audio_sample (audio_sample),
    .audio_ready  (audio_ready),
    .net_ready    (net_ready),
    .tx_valid     (tx_valid),
    .tx_byte      (tx_byte),
    .tx_start     (tx_start),
    .tx_last      (tx_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // A pop request against an empty FIFO would mean the launch condition is broken
  always @(posedge clk) begin
    if (!reset && dut.popWanted && dut.fifoEmpty) begin
      failures++;
      $display("[TB] FAIL fifo_underflow pop requested with empty FIFO at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Runs the link side from the current cycle until 16 bytes are accepted (or budget expires)
  task automatic capturePacket(input logic [63:0] readyPattern);
    logic       prevStall;
    logic [7:0] prevByte;
    logic       prevStartV;
    logic       prevLastV;
    capCount = 0; capBusy = 0; capHoldErr = 0; capStalls = 0; capStallByte = 8'h00;
    prevStall = 1'b0; prevByte = 8'h00; prevStartV = 1'b0; prevLastV = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (busy === 1'b1) capBusy++;
      if (prevStall && (tx_byte !== prevByte || tx_start !== prevStartV || tx_last !== prevLastV))
        capHoldErr++;
      net_ready  = readyPattern[cyc];
      prevStall  = (tx_valid === 1'b1) && !net_ready;
      prevByte   = tx_byte;
      prevStartV = tx_start;
      prevLastV  = tx_last;
      if (tx_valid === 1'b1 && net_ready) begin
        if (capCount < 16) begin
          capBytes[capCount] = tx_byte;
          capStart[capCount] = tx_start;
          capLast[capCount]  = tx_last;
        end
        capCount++;
        if (capCount == 16) break;
      end else if (tx_valid === 1'b1) begin
        capStalls++;
        capStallByte = tx_byte;
      end
      @(negedge clk);
    end
    net_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, audio_ready, tx_valid, tx_start, tx_last, busy, tx_byte} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL reset_values got=%b exp=0", {cmd_ready, audio_ready, tx_valid, tx_start, tx_last, busy, tx_byte});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, audio_ready, tx_valid, busy} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got=%b exp=1100", {cmd_ready, audio_ready, tx_valid, busy});
    end
  endtask

  task automatic test_control;
    cmd_valid = 1'b1; cmd = 2'b10; cmd_data = 16'hBEEF; phone_num = 8'h05; net_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_cmd_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({tx_valid, tx_start, tx_byte} !== {2'b11, 8'h40}) begin
      failures++;
      $display("[TB] FAIL ctrl_latency got=%b/%b/%h exp=1/1/40", tx_valid, tx_start, tx_byte);
    end
    foreach (expBytes[i]) expBytes[i] = 8'h00;
    expBytes[0] = 8'h40; expBytes[1] = 8'h05; expBytes[2] = 8'h02; expBytes[3] = 8'hBE; expBytes[4] = 8'hEF;
    capturePacket('1);
    checks++;
    if (capCount !== 16) begin failures++; $display("[TB] FAIL ctrl_len got=%0d exp=16", capCount); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i] || capStart[i] !== (i == 0) || capLast[i] !== (i == 15)) begin
        failures++;
        $display("[TB] FAIL ctrl_byte%0d got=%h s=%b l=%b exp=%h s=%b l=%b", i, capBytes[i], capStart[i], capLast[i],
                 expBytes[i], (i == 0), (i == 15));
      end
    end
    checks++;
    if (capBusy !== 16) begin failures++; $display("[TB] FAIL ctrl_busy_cycles got=%0d exp=16", capBusy); end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, cmd_ready} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL ctrl_end got=%b exp=001", {tx_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_backpressure;
    cmd_valid = 1'b1; cmd = 2'b01; cmd_data = 16'hBEEF; phone_num = 8'h06; net_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    foreach (expBytes[i]) expBytes[i] = 8'h00;
    expBytes[0] = 8'h40; expBytes[1] = 8'h06; expBytes[2] = 8'h01; expBytes[3] = 8'hBE; expBytes[4] = 8'hEF;
    capturePacket(64'hFFFF_FFFF_FFFF_FFE7);
    checks++;
    if (capCount !== 16) begin failures++; $display("[TB] FAIL bp_len got=%0d exp=16", capCount); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin
        failures++;
        $display("[TB] FAIL bp_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]);
      end
    end
    checks++;
    if (capStalls !== 2 || capStallByte !== 8'hBE || capHoldErr !== 0) begin
      failures++;
      $display("[TB] FAIL bp_hold stalls=%0d byte=%h holdErr=%0d exp 2/BE/0", capStalls, capStallByte, capHoldErr);
    end
    checks++;
    if (capBusy !== 18) begin failures++; $display("[TB] FAIL bp_busy_cycles got=%0d exp=18", capBusy); end
    @(negedge clk);
  endtask

  task automatic test_audio;
    int k;
    phone_num = 8'h09; net_ready = 1'b1;
    for (k = 1; k <= 7; k++) begin
      audio_valid = 1'b1; audio_sample = 16'(k * 16'h1111);
      checks++;
      if (audio_ready !== 1'b1) begin failures++; $display("[TB] FAIL audio_ready_push%0d got=%b exp=1", k, audio_ready); end
      @(negedge clk);
    end
    audio_valid = 1'b0;
    for (int w = 0; w < 10 && tx_valid !== 1'b1; w++) @(negedge clk);
    checks++;
    if ({tx_valid, tx_start} !== 2'b11) begin failures++; $display("[TB] FAIL audio_launch got=%b exp=11", {tx_valid, tx_start}); end
    expBytes[0] = 8'h80; expBytes[1] = 8'h09;
    for (int s = 0; s < 7; s++) begin
      expBytes[2 + 2 * s] = 8'((s + 1) * 8'h11);
      expBytes[3 + 2 * s] = 8'((s + 1) * 8'h11);
    end
    capturePacket('1);
    checks++;
    if (capCount !== 16) begin failures++; $display("[TB] FAIL audio_len got=%0d exp=16", capCount); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i] || capLast[i] !== (i == 15)) begin
        failures++;
        $display("[TB] FAIL audio_byte%0d got=%h l=%b exp=%h l=%b", i, capBytes[i], capLast[i], expBytes[i], (i == 15));
      end
    end
    @(negedge clk);
    checks++;
    if (dut.fifoCount !== 4'd0 || tx_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL audio_drain count=%0d valid=%b exp 0/0", dut.fifoCount, tx_valid);
    end
  endtask

  task automatic test_priority;
    cmd_valid = 1'b1; cmd = 2'b01; cmd_data = 16'h1234; phone_num = 8'h03; net_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      audio_valid = 1'b1; audio_sample = {8'(2 * k + 1), 8'(2 * k + 2)};
      @(negedge clk);
    end
    audio_valid = 1'b0;
    cmd_valid = 1'b1; cmd = 2'b11; cmd_data = 16'hCAFE; phone_num = 8'h07;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL prio_cmd_ready_busy got=%b exp=0", cmd_ready); end
    foreach (expBytes[i]) expBytes[i] = 8'h00;
    expBytes[0] = 8'h40; expBytes[1] = 8'h03; expBytes[2] = 8'h01; expBytes[3] = 8'h12; expBytes[4] = 8'h34;
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL prio_first_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, cmd_ready} !== 2'b01) begin failures++; $display("[TB] FAIL prio_gap1 got=%b exp=01", {tx_valid, cmd_ready}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h40}) begin failures++; $display("[TB] FAIL prio_ctrl_wins got=%b/%h exp=1/40", tx_valid, tx_byte); end
    expBytes[1] = 8'h07; expBytes[2] = 8'h03; expBytes[3] = 8'hCA; expBytes[4] = 8'hFE;
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL prio_ctrl_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL prio_gap2 got=%b exp=0", tx_valid); end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h80}) begin failures++; $display("[TB] FAIL prio_audio_next got=%b/%h exp=1/80", tx_valid, tx_byte); end
    expBytes[0] = 8'h80; expBytes[1] = 8'h07;
    for (int i = 0; i < 14; i++) expBytes[2 + i] = 8'(i + 1);
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL prio_audio_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_fifo_full;
    phone_num = 8'h0B; net_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      audio_valid = 1'b1; audio_sample = 16'(k * 16'h1111);
      @(negedge clk);
    end
    audio_sample = 16'h9999;
    checks++;
    if (audio_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", audio_ready); end
    repeat (3) @(negedge clk);
    audio_valid = 1'b0;
    checks++;
    if (dut.fifoCount !== 4'd8 || audio_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_no_write count=%0d ready=%b exp 8/0", dut.fifoCount, audio_ready);
    end
    expBytes[0] = 8'h80; expBytes[1] = 8'h0B;
    for (int s = 0; s < 7; s++) begin
      expBytes[2 + 2 * s] = 8'((s + 1) * 8'h11);
      expBytes[3 + 2 * s] = 8'((s + 1) * 8'h11);
    end
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL full_pkt1_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
    checks++;
    if (dut.fifoCount !== 4'd1) begin failures++; $display("[TB] FAIL full_left count=%0d exp=1", dut.fifoCount); end
    for (int k = 10; k <= 15; k++) begin
      audio_valid = 1'b1; audio_sample = 16'(k * 16'h1111);
      @(negedge clk);
    end
    audio_valid = 1'b0;
    for (int w = 0; w < 10 && tx_valid !== 1'b1; w++) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_pkt2_launch got=%b exp=1", tx_valid); end
    expBytes[2] = 8'h88; expBytes[3] = 8'h88;
    for (int s = 0; s < 6; s++) begin
      expBytes[4 + 2 * s] = 8'((s + 10) * 8'h11);
      expBytes[5 + 2 * s] = 8'((s + 10) * 8'h11);
    end
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL full_pkt2_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    phone_num = 8'h0D; net_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      audio_valid = 1'b1; audio_sample = 16'(k * 16'h1111);
      @(negedge clk);
    end
    audio_valid = 1'b0;
    for (int w = 0; w < 10 && tx_valid !== 1'b1; w++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (tx_byte !== 8'h33) begin failures++; $display("[TB] FAIL rst_byte6 got=%h exp=33", tx_byte); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, audio_ready, tx_valid, tx_start, tx_last, busy, tx_byte} !== 14'h0 || dut.fifoCount !== 4'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid got=%b count=%0d exp=0/0",
               {cmd_ready, audio_ready, tx_valid, tx_start, tx_last, busy, tx_byte}, dut.fifoCount);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, cmd_ready} !== 2'b01) begin failures++; $display("[TB] FAIL rst_no_continue got=%b exp=01", {tx_valid, cmd_ready}); end
    cmd_valid = 1'b1; cmd = 2'b11; cmd_data = 16'h5A5A; phone_num = 8'h0C;
    @(negedge clk);
    cmd_valid = 1'b0;
    foreach (expBytes[i]) expBytes[i] = 8'h00;
    expBytes[0] = 8'h40; expBytes[1] = 8'h0C; expBytes[2] = 8'h03; expBytes[3] = 8'h5A; expBytes[4] = 8'h5A;
    capturePacket('1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capBytes[i] !== expBytes[i]) begin failures++; $display("[TB] FAIL rst_ctrl_byte%0d got=%h exp=%h", i, capBytes[i], expBytes[i]); end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; phone_num = 8'h00; cmd_data = 16'h0000;
    audio_valid = 1'b0; audio_sample = 16'h0000; net_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_control();
    test_backpressure();
    test_audio();
    test_priority();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transport_send.md
Name: transport_send

Overview:
Transmit side of the transport layer. Accepts control commands and 16-bit audio samples from the session layer. Frames them into fixed-size byte packets: header byte, destination phone byte, payload, zero padding. Streams the packets one byte per accepted cycle to the network/link layer, using the same 0x40 (control) / 0x80 (audio) header coding the receive side parses.

Parameters:
PACKET_BYTES, 16, bytes per packet (128-bit packet); must be >= 16
AUDIO_DEPTH, 8, audio sample FIFO depth in 16-bit samples; must be >= 7
SAMPLES_PER_PKT, 7, audio samples carried per audio packet (bytes 2..15)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  session presents a control command
cmd  in  2  control command code
phone_num  in  8  destination phone number; sampled at packet launch, both packet types
cmd_data  in  16  control payload
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
audio_valid  in  1  audio sample present
audio_sample  in  16  audio sample
audio_ready  out  1  sample accepted when audio_valid & audio_ready
net_ready  in  1  link layer accepts current byte
tx_valid  out  1  tx_byte valid
tx_byte  out  8  packet byte
tx_start  out  1  high while byte 0 of a packet is presented
tx_last  out  1  high while byte PACKET_BYTES-1 is presented
busy  out  1  packet in flight

Behaviour:
- Reset values: cmd_ready=0, audio_ready=0, tx_valid=0, tx_byte=0, tx_start=0, tx_last=0, busy=0. Audio FIFO is emptied, FSM goes to IDLE, byte index = 0.
- Reset mid-packet: packet is aborted. No partial continuation after reset deasserts.
- FSM states:
  - IDLE: cmd_ready=1, tx_valid=0.
  - SEND: tx_valid=1, busy=1. Byte index 0..PACKET_BYTES-1 advances only on a cycle where net_ready=1.
- Launch priority, evaluated in IDLE:
  - cmd_valid: launch control packet. Latch cmd, cmd_data and phone_num in that cycle.
  - else FIFO count >= SAMPLES_PER_PKT: launch audio packet. Latch phone_num.
  - Both conditions true: control wins. Audio waits.
- Latency: launch at cycle N -> byte 0 presented at cycle N+1 with tx_start=1.
- Byte hold: tx_byte, tx_start and tx_last stay stable while net_ready=0.
- Control packet layout:
  - byte0 = 0x40
  - byte1 = phone
  - byte2 = {6'b0, cmd}
  - byte3 = cmd_data[15:8]
  - byte4 = cmd_data[7:0]
  - bytes 5..PACKET_BYTES-1 = 0x00
- Audio packet layout:
  - byte0 = 0x80
  - byte1 = phone
  - bytes 2..15 = SAMPLES_PER_PKT samples, MSB byte first, oldest sample first
  - bytes 16..PACKET_BYTES-1 = 0x00
- Audio FIFO pop: happens on acceptance of each odd payload byte (indices 3, 5, ..., 15). The head sample drives both of its bytes.
  - Underflow is impossible because the launch condition guarantees enough samples; the bench asserts it never occurs.
- Packet end: acceptance of byte PACKET_BYTES-1 returns the FSM to IDLE.
  - Next launch decision is made in that IDLE cycle. Minimum gap between packets: 1 cycle with tx_valid=0.
- audio_ready = !fifo_full, in all states, including during SEND.
  - Simultaneous push and pop: count unchanged. Data order preserved.
  - Full FIFO: audio_ready=0 and no write. Samples are never dropped silently.
- cmd_ready = 1 only in IDLE. No command is accepted while busy. A cmd_valid during SEND waits (session holds it).
- Byte index width: clog2(PACKET_BYTES). It wraps only via the FSM return to IDLE, never arithmetically.

Decomposition:
- Shared package transport_pkg: header constants HDR_CTRL=8'h40 and HDR_AUDIO=8'h80, the PACKET_BYTES default, the state enum {IDLE, SEND}, and payload byte offsets. The receive side uses the same header constants from this package.
- One sub-module, tx_sample_fifo: synchronous FIFO with parameters WIDTH=16 and DEPTH=AUDIO_DEPTH.
  - Outputs: dout, count, full, empty.
  - Inputs: push, pop.
  - Pop and push in the same cycle are legal. Reset clears it.

Test Plan:
- Control frame: cmd=2'b10, cmd_data=16'hBEEF, phone_num=8'h05, net_ready=1 -> at N+1 bytes 40,05,02,BE,EF followed by eleven 00. tx_start on byte 0, tx_last on byte 15, busy high for 16 cycles.
- Audio frame: push samples 0x1111..0x7777, phone_num=8'h09 -> bytes 80,09,11,11,22,22,...,77,77. FIFO count returns to 0.
- Back-pressure: net_ready toggles 1,0,0,1 during byte 3 of a control packet -> tx_byte holds BE across the stall. No duplicated or skipped byte. Total packet still 16 bytes.
- Priority: FIFO holds 7 samples and cmd_valid is asserted in the same IDLE cycle -> control packet sent first. Audio packet launches after a 1-cycle idle gap.
- FIFO full: push 8 samples with net_ready=0 throughout -> audio_ready=0 after the 8th sample. Further audio_valid is ignored. After draining, data order is intact.
- Reset at byte 6 of an audio packet -> next cycle all outputs at reset values and FIFO empty. A new control packet afterwards is framed correctly.
